cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Transmit side of the common data bus. Collects completed results from the ALU RS, the LSB
//  and the branch unit, each through a small FIFO. Round-robin arbitration drives one
//  registered broadcast (ROB label + value) per cycle onto the CDB.
//  ROB, RS and LSB snoop this broadcast for wakeup and writeback.
// PARAMETERS
//  LAB_W   5   label width = `ROB_ID_WIDTH+1 (MSB is the ROB label valid/tag bit, passed through)
//  VAL_W   32  result value width (`VAL_WIDTH)
//  DEPTH   2   entries per source FIFO; power of two, >=2
// PORTS
//  clk            in   1      core clock
//  rst_in         in   1      asynchronous, active-low reset
//  rdy_in         in   1      global enable; low freezes all state
//  flush          in   1      branch mispredict flush; synchronous
//  alu_valid_in   in   1      ALU result offered
//  alu_ready_out  out  1      ALU FIFO can accept
//  alu_lab_in     in   LAB_W  ALU result ROB label
//  alu_val_in     in   VAL_W  ALU result value
//  lsb_valid_in / lsb_ready_out / lsb_lab_in / lsb_val_in   same as alu_*, for the LSB
//  bru_valid_in / bru_ready_out / bru_lab_in / bru_val_in   same as alu_*, for the branch unit
//  cdb_valid_out  out  1      broadcast valid this cycle
//  cdb_lab_out    out  LAB_W  broadcast ROB label
//  cdb_val_out    out  VAL_W  broadcast value
//  cdb_src_out    out  2      0=ALU 1=LSB 2=BRU
// BEHAVIOUR
//  Reset (rst_in=0, async):
//   - FIFOs empty; rr_ptr=0 (ALU).
//   - cdb_valid_out/lab/val/src = 0.
//   - *_ready_out = 1: combinational !full, so high while in reset.
//  Push:
//   - Condition: x_valid_in & x_ready_out & rdy_in & !flush at the clock edge.
//   - x_ready_out = !full from current state only; no combinational path from any valid_in.
//   - Full FIFO refuses a push even if it pops in the same cycle; no bypass.
//  Arbitration (rdy_in=1, !flush):
//   - Candidates: non-empty FIFO heads.
//   - Search starts at rr_ptr, order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
//   - First hit s is granted: head popped, output regs loaded, cdb_valid_out=1, rr_ptr <= (s+1)%3.
//   - No candidate: cdb_valid_out <= 0, rr_ptr unchanged, lab/val/src hold their last values.
//  Latency and ordering:
//   - An entry accepted at edge k is broadcast at the earliest in the cycle after edge k+1.
//   - Each accepted entry is broadcast exactly once.
//   - Per-source order is FIFO; no ordering across sources.
//  Pointers: wrap mod DEPTH; extra wrap bit distinguishes full from empty.
//  rdy_in=0: no push, no pop, rr_ptr and outputs held; consumers gate the broadcast with rdy_in.
//  flush=1 (ignores rdy_in): at the next edge
//   - all FIFOs cleared, rr_ptr=0, cdb_valid_out=0;
//   - pushes offered in the flush cycle are dropped.
//  Simultaneous full-FIFO push and pop: push refused, pop proceeds; ready rises the next cycle.
// CONFIGURATION
//  CDB_PERF_EN defined:
//   - Adds outputs perf_bcast_out[31:0] and perf_stall_out[31:0].
//   - perf_bcast_out: +1 per edge with rdy_in & a grant.
//   - perf_stall_out: +1 per edge with rdy_in & any x_valid_in & !x_ready_out.
//   - Both wrap mod 2^32; cleared by reset, not by flush.
//  CDB_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//  1 Hold rst_in=0 -> cdb_valid_out=0, lab=0, val=0, src=0; all three ready_out=1.
//  2 ALU push lab=3, val=0x1234 at edge k -> in the cycle after edge k+1: valid=1, lab=3,
//    val=0x1234, src=0; valid=0 the cycle after that.
//  3 ALU/LSB/BRU push lab 1/2/3 on the same edge -> three consecutive broadcasts lab 1,2,3.
//    Then LSB+BRU push lab 4/5 -> order 4 then 5; rr_ptr continues from BRU+1=ALU.
//  4 DEPTH=2; LSB offers 4 results back-to-back while the ALU pushes every cycle:
//    - lsb_ready_out drops while LSB FIFO full;
//    - all 4 LSB labels broadcast in order, none duplicated, ALU/LSB grants alternating.
//  5 Load 2 entries in each FIFO, assert flush with an ALU push that cycle:
//    - next cycle valid=0, all ready=1;
//    - no broadcast of any pre-flush entry afterwards.
//  6 rdy_in=0 for 3 cycles mid-stream -> outputs frozen.
//    Counting broadcasts only in rdy_in=1 cycles: every label exactly once.
//  7 CDB_PERF_EN: after test 3 perf_bcast_out=5. After test 4 perf_stall_out equals the number
//    of refused LSB offers.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Transmit side of the common data bus. The ALU RS, the LSB and the branch
//   unit each hand completed results (ROB label + value) into a small private
//   FIFO. A round-robin arbiter picks one non-empty FIFO head per cycle and
//   loads it into the registered broadcast outputs, which the ROB, RS and LSB
//   snoop for wakeup and writeback.
//
// Optional build macro:
//   CDB_PERF_EN  adds perf_bcast_out / perf_stall_out event counters.
//
// Ports:
//   clk                      core clock
//   rst_in                   asynchronous active-low reset
//   rdy_in                   global enable; low freezes all state
//   flush                    synchronous mispredict flush (overrides rdy_in)
//   {alu,lsb,bru}_valid_in   result offered by the source
//   {alu,lsb,bru}_ready_out  source FIFO not full (depends on state only)
//   {alu,lsb,bru}_lab_in     result ROB label (MSB = tag bit, passed through)
//   {alu,lsb,bru}_val_in     result value
//   cdb_valid_out            broadcast valid this cycle
//   cdb_lab_out              broadcast ROB label
//   cdb_val_out              broadcast value
//   cdb_src_out              broadcasting source: 0=ALU 1=LSB 2=BRU
//   perf_bcast_out           (CDB_PERF_EN) broadcasts granted while enabled
//   perf_stall_out           (CDB_PERF_EN) enabled edges with a refused offer
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int LAB_W = 5,
    parameter int VAL_W = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             alu_valid_in,
    output logic             alu_ready_out,
    input  logic [LAB_W-1:0] alu_lab_in,
    input  logic [VAL_W-1:0] alu_val_in,
    input  logic             lsb_valid_in,
    output logic             lsb_ready_out,
    input  logic [LAB_W-1:0] lsb_lab_in,
    input  logic [VAL_W-1:0] lsb_val_in,
    input  logic             bru_valid_in,
    output logic             bru_ready_out,
    input  logic [LAB_W-1:0] bru_lab_in,
    input  logic [VAL_W-1:0] bru_val_in,
    output logic             cdb_valid_out,
    output logic [LAB_W-1:0] cdb_lab_out,
    output logic [VAL_W-1:0] cdb_val_out,
    output logic [1:0]       cdb_src_out
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]      perf_bcast_out,
    output logic [31:0]      perf_stall_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = LAB_W + VAL_W;
    localparam int NSRC = 3;

    // Sources gathered into arrays so the FIFOs can be generated uniformly.
    logic [NSRC-1:0] in_valid;
    logic [EW-1:0]   in_data [NSRC];
    logic [NSRC-1:0] empty;
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;
    logic [EW-1:0]   head [NSRC];

    assign in_valid   = {bru_valid_in, lsb_valid_in, alu_valid_in};
    assign in_data[0] = {alu_lab_in, alu_val_in};
    assign in_data[1] = {lsb_lab_in, lsb_val_in};
    assign in_data[2] = {bru_lab_in, bru_val_in};

    // Ready is purely a function of FIFO state: a full FIFO refuses even when
    // it is being popped on the same edge (no bypass through the pop).
    assign alu_ready_out = !full[0];
    assign lsb_ready_out = !full[1];
    assign bru_ready_out = !full[2];

    logic       grant_valid;
    logic [1:0] grant_src;
    logic [2:0] arb_idx;
    logic [1:0] rr_ptr_reg;
    logic [1:0] rr_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_fifo
            logic [EW-1:0] mem_reg [DEPTH];
            // Extra MSB on each pointer separates full from empty.
            logic [AW:0]   wr_ptr_reg;
            logic [AW:0]   rd_ptr_reg;

            assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                               (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            assign push[gi]  = in_valid[gi] && !full[gi] && rdy_in && !flush;
            assign pop[gi]   = grant_valid && (grant_src == 2'(gi)) && rdy_in && !flush;
            assign head[gi]  = mem_reg[rd_ptr_reg[AW-1:0]];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_reg[wr_ptr_reg[AW-1:0]] <= in_data[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_in) begin
                if (!rst_in) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else if (flush) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    // Round-robin search starting at rr_ptr, visiting rr_ptr, +1, +2 (mod 3).
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = 2'd0;
        arb_idx     = 3'd0;
        for (int k = 0; k < NSRC; k++) begin
            arb_idx = {1'b0, rr_ptr_reg} + 3'(k);
            if (arb_idx >= 3'd3) arb_idx = arb_idx - 3'd3;
            if (!grant_valid && !empty[arb_idx[1:0]]) begin
                grant_valid = 1'b1;
                grant_src   = arb_idx[1:0];
            end
        end
        rr_ptr_next = (grant_src == 2'd2) ? 2'd0 : grant_src + 2'd1;
    end

    // Broadcast registers. lab/val/src deliberately hold on idle cycles.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_out <= 1'b0;
            cdb_lab_out   <= '0;
            cdb_val_out   <= '0;
            cdb_src_out   <= 2'd0;
            rr_ptr_reg    <= 2'd0;
        end else if (flush) begin
            cdb_valid_out <= 1'b0;
            rr_ptr_reg    <= 2'd0;
        end else if (rdy_in) begin
            if (grant_valid) begin
                cdb_valid_out              <= 1'b1;
                {cdb_lab_out, cdb_val_out} <= head[grant_src];
                cdb_src_out                <= grant_src;
                rr_ptr_reg                 <= rr_ptr_next;
            end else begin
                cdb_valid_out <= 1'b0;
            end
        end
    end

`ifdef CDB_PERF_EN
    logic [31:0] perf_bcast_reg;
    logic [31:0] perf_stall_reg;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            perf_bcast_reg <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (rdy_in && grant_valid && !flush) perf_bcast_reg <= perf_bcast_reg + 32'd1;
            if (rdy_in && |(in_valid & full))    perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_bcast_out = perf_bcast_reg;
    assign perf_stall_out = perf_stall_reg;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter with hand-computed expected broadcasts:
//   reset state, single-result latency, round-robin order, FIFO back-pressure,
//   flush, and rdy_in freeze. Perf counters are checked when CDB_PERF_EN is set.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush = 1'b0;
    logic        alu_valid_in = 1'b0, lsb_valid_in = 1'b0, bru_valid_in = 1'b0;
    logic        alu_ready_out, lsb_ready_out, bru_ready_out;
    logic [4:0]  alu_lab_in = '0, lsb_lab_in = '0, bru_lab_in = '0;
    logic [31:0] alu_val_in = '0, lsb_val_in = '0, bru_val_in = '0;
    logic        cdb_valid_out;
    logic [4:0]  cdb_lab_out;
    logic [31:0] cdb_val_out;
    logic [1:0]  cdb_src_out;
`ifdef CDB_PERF_EN
    logic [31:0] perf_bcast_out, perf_stall_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter #(.LAB_W(5), .VAL_W(32), .DEPTH(2)) dut (
        .clk           (clk),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush         (flush),
        .alu_valid_in  (alu_valid_in),
        .alu_ready_out (alu_ready_out),
        .alu_lab_in    (alu_lab_in),
        .alu_val_in    (alu_val_in),
        .lsb_valid_in  (lsb_valid_in),
        .lsb_ready_out (lsb_ready_out),
        .lsb_lab_in    (lsb_lab_in),
        .lsb_val_in    (lsb_val_in),
        .bru_valid_in  (bru_valid_in),
        .bru_ready_out (bru_ready_out),
        .bru_lab_in    (bru_lab_in),
        .bru_val_in    (bru_val_in),
        .cdb_valid_out (cdb_valid_out),
        .cdb_lab_out   (cdb_lab_out),
        .cdb_val_out   (cdb_val_out),
        .cdb_src_out   (cdb_src_out)
`ifdef CDB_PERF_EN
        ,
        .perf_bcast_out(perf_bcast_out),
        .perf_stall_out(perf_stall_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one edge; outputs are then sampled/inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bcast(input string tag, input logic [4:0] lab, input logic [1:0] src);
        check({tag, ".valid"}, cdb_valid_out, 1'b1);
        check({tag, ".lab"}, cdb_lab_out, lab);
        check({tag, ".src"}, cdb_src_out, src);
    endtask

    logic [4:0] exp_lab [8];
    logic [1:0] exp_src [8];
    logic [4:0] got_lab [16];
    logic [1:0] got_src [16];

    initial begin
        int lsb_i, alu_i, refused, nb, late;
        logic lsb_take, alu_take;

        // ---- 1: reset state ----
        tick(); tick();
        check("rst.valid", cdb_valid_out, 1'b0);
        check("rst.lab", cdb_lab_out, 5'd0);
        check("rst.val", cdb_val_out, 32'd0);
        check("rst.src", cdb_src_out, 2'd0);
        check("rst.alu_rdy", alu_ready_out, 1'b1);
        check("rst.lsb_rdy", lsb_ready_out, 1'b1);
        check("rst.bru_rdy", bru_ready_out, 1'b1);
        rst_in = 1'b1;

        // ---- 2: single ALU result, two-edge latency ----
        alu_valid_in = 1'b1; alu_lab_in = 5'd3; alu_val_in = 32'h1234;
        tick();
        alu_valid_in = 1'b0;
        check("t2.early_valid", cdb_valid_out, 1'b0);
        tick();
        check_bcast("t2.b", 5'd3, 2'd0);
        check("t2.val", cdb_val_out, 32'h1234);
        tick();
        check("t2.after_valid", cdb_valid_out, 1'b0);

        // ---- 3: round robin, after a fresh reset ----
        rst_in = 1'b0; #2; rst_in = 1'b1;
        alu_valid_in = 1'b1; alu_lab_in = 5'd1; alu_val_in = 32'h101;
        lsb_valid_in = 1'b1; lsb_lab_in = 5'd2; lsb_val_in = 32'h102;
        bru_valid_in = 1'b1; bru_lab_in = 5'd3; bru_val_in = 32'h103;
        tick();
        alu_valid_in = 1'b0; lsb_valid_in = 1'b0; bru_valid_in = 1'b0;
        tick(); check_bcast("t3.b1", 5'd1, 2'd0);
        check("t3.b1.val", cdb_val_out, 32'h101);
        tick(); check_bcast("t3.b2", 5'd2, 2'd1);
        tick(); check_bcast("t3.b3", 5'd3, 2'd2);
        check("t3.b3.val", cdb_val_out, 32'h103);
        lsb_valid_in = 1'b1; lsb_lab_in = 5'd4; lsb_val_in = 32'h104;
        bru_valid_in = 1'b1; bru_lab_in = 5'd5; bru_val_in = 32'h105;
        tick();
        lsb_valid_in = 1'b0; bru_valid_in = 1'b0;
        check("t3.gap_valid", cdb_valid_out, 1'b0);
        tick(); check_bcast("t3.b4", 5'd4, 2'd1);
        tick(); check_bcast("t3.b5", 5'd5, 2'd2);
        tick(); check("t3.idle_valid", cdb_valid_out, 1'b0);
        check("t3.idle_lab_hold", cdb_lab_out, 5'd5);
`ifdef CDB_PERF_EN
        check("t3.perf_bcast", perf_bcast_out, 32'd5);
`endif

        // ---- 4: LSB back-pressure with a well-behaved ALU producer ----
        exp_lab = '{5'd20, 5'd10, 5'd21, 5'd11, 5'd22, 5'd12, 5'd23, 5'd13};
        exp_src = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        lsb_i = 0; alu_i = 0; refused = 0; nb = 0;
        for (int c = 0; c < 12; c++) begin
            lsb_valid_in = (lsb_i < 4);
            lsb_lab_in   = 5'(10 + lsb_i);
            lsb_val_in   = 32'(lsb_i);
            alu_valid_in = (alu_i < 4) && alu_ready_out;
            alu_lab_in   = 5'(20 + alu_i);
            alu_val_in   = 32'(alu_i);
            lsb_take = lsb_valid_in && lsb_ready_out;
            alu_take = alu_valid_in;
            if (lsb_valid_in && !lsb_ready_out) refused++;
            tick();
            if (lsb_take) lsb_i++;
            if (alu_take) alu_i++;
            if (cdb_valid_out && nb < 16) begin
                got_lab[nb] = cdb_lab_out;
                got_src[nb] = cdb_src_out;
                nb++;
            end
        end
        lsb_valid_in = 1'b0; alu_valid_in = 1'b0;
        check("t4.lsb_refused", 64'(refused), 64'd2);
        check("t4.bcast_count", 64'(nb), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4.b%0d.lab", i), got_lab[i], exp_lab[i]);
            check($sformatf("t4.b%0d.src", i), got_src[i], exp_src[i]);
        end
`ifdef CDB_PERF_EN
        check("t4.perf_stall", perf_stall_out, 32'd2);
`endif

        // ---- 5: flush with queued entries and a same-cycle push ----
        alu_valid_in = 1'b1; alu_lab_in = 5'd1;
        lsb_valid_in = 1'b1; lsb_lab_in = 5'd2;
        bru_valid_in = 1'b1; bru_lab_in = 5'd3;
        tick();
        alu_lab_in = 5'd4; lsb_lab_in = 5'd5; bru_lab_in = 5'd6;
        tick();
        check_bcast("t5.preflush", 5'd3, 2'd2);
        lsb_valid_in = 1'b0; bru_valid_in = 1'b0;
        alu_lab_in = 5'd7;
        flush = 1'b1;
        tick();
        flush = 1'b0; alu_valid_in = 1'b0;
        check("t5.valid", cdb_valid_out, 1'b0);
        check("t5.alu_rdy", alu_ready_out, 1'b1);
        check("t5.lsb_rdy", lsb_ready_out, 1'b1);
        check("t5.bru_rdy", bru_ready_out, 1'b1);
        late = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (cdb_valid_out) late++;
        end
        check("t5.postflush_bcasts", 64'(late), 64'd0);

        // ---- 6: rdy_in freeze mid-stream ----
        alu_valid_in = 1'b1; alu_lab_in = 5'd8;  alu_val_in = 32'h908;
        lsb_valid_in = 1'b1; lsb_lab_in = 5'd9;  lsb_val_in = 32'h909;
        bru_valid_in = 1'b1; bru_lab_in = 5'd10; bru_val_in = 32'h90a;
        tick();
        lsb_valid_in = 1'b0; bru_valid_in = 1'b0; alu_valid_in = 1'b0;
        check("t6.early_valid", cdb_valid_out, 1'b0);
        tick();
        check_bcast("t6.b8", 5'd8, 2'd0);
        rdy_in = 1'b0;
        alu_valid_in = 1'b1; alu_lab_in = 5'd11; alu_val_in = 32'h90b;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bcast($sformatf("t6.frz%0d", c), 5'd8, 2'd0);
            check($sformatf("t6.frz%0d.val", c), cdb_val_out, 32'h908);
        end
        rdy_in = 1'b1; alu_valid_in = 1'b0;
        tick(); check_bcast("t6.b9", 5'd9, 2'd1);
        tick(); check_bcast("t6.b10", 5'd10, 2'd2);
        check("t6.b10.val", cdb_val_out, 32'h90a);
        tick(); check("t6.idle_valid", cdb_valid_out, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
